// File: rtl/vga_blitter_if.sv
// Command channel from the CPU-side bus glue into the blitter.
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready; the master holds all fields until then.
interface vga_blitter_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [8:0] cmd_x;
  logic [8:0] cmd_y;
  logic [8:0] cmd_w;
  logic [8:0] cmd_h;
  logic [7:0] cmd_color;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/vga_blitter.sv
// Clipped pixel / rectangle / clear-screen writer feeding the VGA driver's framebuffer port.
// One registered pixel write per clock, row-major, addresses built incrementally from a row base.
module vga_blitter #(
  parameter int FB_WIDTH   = 400,
  parameter int FB_HEIGHT  = 300,
  parameter int ROW_SHIFT  = 9,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk50M,
  input  logic                  rst,
  vga_blitter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [9:0]            FB_W   = 10'(FB_WIDTH);
  localparam logic [9:0]            FB_H   = 10'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(1) << ROW_SHIFT;

  state_t state, state_n;

  logic [9:0]            col, row;
  logic [9:0]            eff_w_q, eff_h_q;
  logic [ADDR_WIDTH-1:0] row_base;

  logic [9:0]            op_x, op_y, op_w, op_h;
  logic [9:0]            room_w, room_h, eff_w, eff_h;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  reject, accept, ready_int;
  logic                  last_col, last_row;

  // Normalise every opcode to a rectangle, then reject and clip in 10-bit space.
  always_comb begin
    op_x = {1'b0, bus.cmd_x};
    op_y = {1'b0, bus.cmd_y};
    op_w = {1'b0, bus.cmd_w};
    op_h = {1'b0, bus.cmd_h};
    case (bus.cmd_op)
      2'd0: begin
        op_w = 10'd1;
        op_h = 10'd1;
      end
      2'd2: begin
        op_x = 10'd0;
        op_y = 10'd0;
        op_w = FB_W;
        op_h = FB_H;
      end
      default: ;
    endcase
    reject = (bus.cmd_op == 2'd3) || (op_x >= FB_W) || (op_y >= FB_H) ||
             (op_w == 10'd0) || (op_h == 10'd0);
    room_w     = FB_W - op_x;
    room_h     = FB_H - op_y;
    eff_w      = (op_w < room_w) ? op_w : room_w;
    eff_h      = (op_h < room_h) ? op_h : room_h;
    start_addr = (ADDR_WIDTH'(op_y) << ROW_SHIFT) + ADDR_WIDTH'(op_x);
  end

  assign ready_int     = (state == IDLE) && !rst;
  assign bus.cmd_ready = ready_int;
  assign accept        = bus.cmd_valid && ready_int;
  assign last_col      = (col == eff_w_q - 10'd1);
  assign last_row      = (row == eff_h_q - 10'd1);
  assign dbg_state     = state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = reject ? DONE : FILL;
      FILL: if (last_col && last_row) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output flags are registered from the next state so the first write lands the cycle after acceptance.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      eff_w_q      <= '0;
      eff_h_q      <= '0;
      row_base     <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      write_enable <= (state_n == FILL);
      busy         <= (state_n != IDLE);
      done         <= (state_n == DONE);
      if (accept) begin
        col      <= '0;
        row      <= '0;
        eff_w_q  <= eff_w;
        eff_h_q  <= eff_h;
        row_base <= start_addr;
        if (!reject) begin
          write_addr <= start_addr;
          write_data <= bus.cmd_color;
        end
      end else if (state == FILL && state_n == FILL) begin
        if (last_col) begin
          col        <= '0;
          row        <= row + 10'd1;
          row_base   <= row_base + STRIDE;
          write_addr <= row_base + STRIDE;
        end else begin
          col        <= col + 10'd1;
          write_addr <= write_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: doc/vga_blitter.md
# vga_blitter

Pixel-writing engine that sits directly upstream of the VGA driver and owns its framebuffer write port (`write_addr`, `write_data`, `write_enable`). It accepts single-pixel, rectangle-fill and clear-screen commands from the CPU-side bus glue. It clips each command to the 400x300 framebuffer and streams one 8-bit RRRGGGBB pixel write per clock into the driver's video RAM. Rectangles are written row-major with no bubbles, so a w x h fill occupies exactly w*h cycles of the write port.

## Interface
- `FB_WIDTH`, 400: framebuffer columns.
- `FB_HEIGHT`, 300: framebuffer rows.
- `ROW_SHIFT`, 9: log2 of the row stride; address = (y << ROW_SHIFT) + x.
- `ADDR_WIDTH`, 18: width of `write_addr`.
- `clk50M` in 1: system clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_op` in 2: 0 = pixel, 1 = rect fill, 2 = clear screen, 3 = reserved (no-op).
- `cmd_x`, `cmd_y` in 9 each: top-left corner; ignored for op 2.
- `cmd_w`, `cmd_h` in 9 each: rect size; used by op 1 only.
- `cmd_color` in 8: pixel value written.
- `write_addr` out ADDR_WIDTH: framebuffer address, registered.
- `write_data` out 8: pixel data, registered.
- `write_enable` out 1: one pixel write this cycle, registered.
- `busy` out 1: high from acceptance until the done cycle.
- `done` out 1: single-cycle pulse on command completion.

## Operation
- A command is accepted on a posedge where `cmd_valid && cmd_ready`. All `cmd_*` fields are latched that cycle and not sampled again.
- Op 0 is treated as a rect with w=1, h=1. Op 2 is treated as x=0, y=0, w=FB_WIDTH, h=FB_HEIGHT.
- Rejection: x >= FB_WIDTH, y >= FB_HEIGHT, w == 0, h == 0, or op 3. A rejected command produces no writes and goes straight to the done cycle.
- Clipping is computed at acceptance in 10-bit unsigned arithmetic:
  - eff_w = min(w, FB_WIDTH - x)
  - eff_h = min(h, FB_HEIGHT - y)
  - No wrap to the next row or to the top of the screen.
- FSM states:
  - IDLE: `cmd_ready`=1. On accept, go to FILL if the command is not rejected, otherwise to DONE.
  - FILL: one write per cycle. Column counter goes 0..eff_w-1. At the end of a row, row_base += 1<<ROW_SHIFT and the column resets. After the write at (eff_w-1, eff_h-1), go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Addresses are incremental: a row-base register plus a column offset. No multiplier.
- `write_data` equals the latched color for every write of a command.
- `write_enable`=0 in IDLE and DONE. `write_addr`/`write_data` hold their last value when not writing.

## Timing
- Reset values: `write_enable`=0, `write_addr`=0, `write_data`=0, `done`=0, `busy`=0, `cmd_ready`=0 while `rst` is high. `cmd_ready`=1 from the first cycle after release.
- Accept at cycle N: first `write_enable` at N+1. Writes on N+1 .. N+eff_w*eff_h, consecutive, no gaps.
- `done` and IDLE: `done` pulses at N+eff_w*eff_h+1 for accepted commands, or at N+1 for rejected ones. The FSM is back in IDLE, with `cmd_ready`=1, the cycle after `done`.
- `busy` is high from N+1 through the `done` cycle inclusive.
- `cmd_valid` while `cmd_ready`=0 is ignored. The requester must hold it until accepted.
- `rst` asserted mid-FILL aborts immediately and asynchronously: `write_enable` drops with no further writes and no `done` pulse.
- Max address is 299*512+399 = 153487, which fits in 18 bits.

## Test plan
- Reset: hold `rst` for 3 cycles. All outputs are 0. `cmd_ready`=1 on the first cycle after release.
- Pixel op 0, x=5, y=3, color=0xE0, accepted at N: exactly one write at N+1 with addr 1541, data 0xE0. `done` at N+2. `cmd_ready`=1 at N+3.
- Rect op 1, x=398, y=10, w=5, h=2, color=0x1C: clipped to 2x2. Writes on 4 consecutive cycles to 5518, 5519, 6030, 6031. `done` follows on the next cycle.
- Clear op 2, color=0xFF: 120000 gapless writes, first addr 0, last addr 153487, every row-start 512-aligned. A second `cmd_valid` during the clear is not accepted until after `done`.
- Rejection: op 1 with x=400, then op 1 with w=0, then op 3. Each gives no writes, `done` at N+1 and `busy` for 1 cycle.
- Abort: assert `rst` 10 cycles into a 50x50 fill. `write_enable` falls in the same cycle with no `done`. A new pixel command after release completes normally.
